// File: rtl/ram_stream_reader.sv
// Read master for a registered-in/registered-out single-port RAM: streams LEN words from BASE
// through a credit-limited output FIFO onto a valid/ready interface.
module ram_stream_reader #(
  parameter int DW         = 16,
  parameter int AW         = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [AW:0]       issue_left, recv_left;
  logic [RD_LAT-1:0] vpipe;
  logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  int unsigned       inflight;
  logic              issue, push, pop, launch;

  assign ram_we     = 1'b0;
  assign ram_din    = '0;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? fifo_mem[rptr] : '0;

  // Credit: words buffered plus reads still in the RAM pipe never exceed FIFO_DEPTH.
  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++)
      inflight = inflight + 32'(vpipe[i]);
  end

  always_comb begin
    launch = (state == IDLE) && start && (len != '0);
    issue  = (state == RUN) && ((32'(count) + inflight) < 32'(FIFO_DEPTH));
    push   = vpipe[RD_LAT-1];
    pop    = dout_valid && dout_ready;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len != '0) ? RUN : DONE;
      RUN:   if (issue && issue_left == (AW+1)'(1)) state_nx = DRAIN;
      DRAIN: if (pop && recv_left == (AW+1)'(1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ram_addr   <= '0;
      issue_left <= '0;
      recv_left  <= '0;
      vpipe      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      state <= state_nx;
      vpipe <= (vpipe << 1) | RD_LAT'(issue);

      if (launch) begin
        ram_addr   <= base_addr;
        issue_left <= len;
        recv_left  <= len;
      end else begin
        if (issue) begin
          ram_addr   <= ram_addr + AW'(1);
          issue_left <= issue_left - (AW+1)'(1);
        end
        if (pop) recv_left <= recv_left - (AW+1)'(1);
      end

      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= ram_q;
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: registered RAM model plus an expected-word queue
// derived from base/len, with random backpressure.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        reset, start, dout_ready;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic        busy, done, ram_we, dout_valid;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din, ram_q, dout;

  logic [15:0] mem [256];
  logic [7:0]  addr_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(.DW(16), .AW(8), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_q(ram_q), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  // Registered address and registered output: two cycles from address to q.
  always @(posedge clk) begin
    addr_r <= ram_addr;
    ram_q  <= mem[addr_r];
  end

  task automatic run_cmd(input logic [7:0] b, input logic [8:0] l, input int rdy_pct,
                         input int inject_at, input bit chk_credit, input bit chk_b2b);
    logic [15:0] exp_q[$];
    logic [15:0] exp_w, prev_d;
    int xfers = 0, first_v = -1, last_x = -1, max_out = 0, outstanding;
    bit got_done = 0, hold = 0;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[8'(int'(b) + i)]);
    @(negedge clk);
    start = 1'b1; base_addr = b; len = l; dout_ready = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc == inject_at) begin
        start = 1'b1; base_addr = 8'h80; len = 9'd5;
      end else begin
        start = 1'b0; base_addr = 8'($urandom); len = 9'($urandom);
      end
      if (done) begin
        got_done = 1;
      end else begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++; $display("FAIL busy_during_cmd cyc=%0d got=%b exp=1", cyc, busy);
        end
        if (hold) begin
          n_cmp++;
          if (dout_valid !== 1'b1 || dout !== prev_d) begin
            n_bad++;
            $display("FAIL stall_stable cyc=%0d got v=%b d=%h exp v=1 d=%h", cyc, dout_valid, dout, prev_d);
          end
        end
        if (chk_credit) begin
          outstanding = int'(8'(ram_addr - b)) - xfers;
          if (outstanding > max_out) max_out = outstanding;
          n_cmp++;
          if (outstanding > 4) begin
            n_bad++; $display("FAIL credit cyc=%0d got=%0d exp<=4", cyc, outstanding);
          end
        end
        if (dout_valid && first_v < 0) first_v = cyc;
        dout_ready = ($urandom_range(99) < rdy_pct);
        if (dout_valid && dout_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL extra_word cyc=%0d got=%h exp=none", cyc, dout);
          end else begin
            exp_w = exp_q.pop_front();
            if (dout !== exp_w) begin
              n_bad++; $display("FAIL data word=%0d got=%h exp=%h", xfers, dout, exp_w);
            end
          end
          xfers++;
          last_x = cyc;
        end
        hold   = dout_valid && !dout_ready;
        prev_d = dout;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (!got_done) begin
      n_bad++; $display("FAIL done_timeout got=0 exp=1");
    end
    n_cmp++;
    if (xfers != int'(l) || exp_q.size() != 0) begin
      n_bad++; $display("FAIL xfer_count got=%0d exp=%0d", xfers, l);
    end
    if (chk_credit) begin
      n_cmp++;
      if (max_out != 4) begin
        n_bad++; $display("FAIL credit_stall got_max=%0d exp=4", max_out);
      end
    end
    if (chk_b2b) begin
      n_cmp++;
      if (first_v < 1 || first_v > 4 || last_x - first_v != int'(l) - 1) begin
        n_bad++; $display("FAIL back_to_back got first=%0d last=%0d exp first<=4 span=%0d", first_v, last_x, int'(l) - 1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL after_done got done=%b busy=%b v=%b exp 0 0 0", done, busy, dout_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dout_ready = 1'b0; base_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0 || dout !== 16'h0 ||
        ram_addr !== 8'h0 || ram_we !== 1'b0 || ram_din !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b done=%b v=%b d=%h a=%h we=%b din=%h exp all 0",
               busy, done, dout_valid, dout, ram_addr, ram_we, ram_din);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1; base_addr = 8'h33; len = 9'd0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_len_done got done=%b busy=%b v=%b exp 1 0 0", done, busy, dout_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_len_after got done=%b busy=%b v=%b exp 0 0 0", done, busy, dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 8'h00; len = 9'd256; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'h0) begin
      n_bad++; $display("FAIL reset_mid got v=%b busy=%b a=%h exp 0 0 00", dout_valid, busy, ram_addr);
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dout_valid !== 1'b0 || done !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL stale_after_reset got activity exp none");
    end
    run_cmd(8'h00, 9'd2, 100, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    test_reset();
    run_cmd(8'h10, 9'd8, 100, 0, 0, 1);   // basic back-to-back
    run_cmd(8'hFE, 9'd4, 100, 0, 0, 1);   // address wrap
    run_cmd(8'h40, 9'd16, 30, 0, 1, 0);   // random backpressure, credit stall
    test_zero_len();
    run_cmd(8'h20, 9'd10, 70, 3, 0, 0);   // start while busy ignored
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
